// File: rtl/control_status_register_file.sv
// Machine-mode CSR storage for the phoeniX core: combinational read port, committed
// writes from the CSR computation stage, 64-bit cycle/instret counters, trap entry and mret.
module control_status_register_file #(
    parameter logic [31:0] MISA_VALUE  = 32'h4000_1104,
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] read_index,
    output logic [31:0] read_data,
    output logic        read_illegal,
    input  logic        write_enable,
    input  logic [11:0] write_index,
    input  logic [31:0] write_data,
    output logic        write_illegal,
    input  logic        instret_increment,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_value,
    input  logic        mret_valid,
    output logic [31:0] trap_vector,
    output logic [31:0] mret_target,
    output logic        global_interrupt_enable
);

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    function automatic logic csr_implemented(input logic [11:0] idx);
        logic hit;
        case (idx)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
            CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH,
            CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH,
            CSR_MHARTID: hit = 1'b1;
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

    // WARL: the reserved mtvec modes 2 and 3 collapse to direct mode.
    function automatic logic [31:0] mtvec_legalize(input logic [31:0] value);
        logic [31:0] legal;
        if (value[1]) begin
            legal = {value[31:2], 2'b00};
        end else begin
            legal = value;
        end
        return legal;
    endfunction

    logic        mie_q,      mie_d;
    logic        mpie_q,     mpie_d;
    logic [31:0] mie_reg_q,  mie_reg_d;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;
    logic [31:0] mtval_q,    mtval_d;
    logic [63:0] cycle_q,    cycle_d;
    logic [63:0] instret_q,  instret_d;

    logic [31:0] mstatus_view_s;
    logic [31:0] tvec_base_s;
    logic        sw_write_s;
    logic        wr_mstatus_s;
    logic        wr_trap_csr_s;

    assign mstatus_view_s = {19'h0_0000, 2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};

    // Read port: unimplemented addresses read zero and flag illegal.
    always_comb begin
        read_data    = 32'h0000_0000;
        read_illegal = 1'b0;
        case (read_index)
            CSR_MSTATUS:                 read_data = mstatus_view_s;
            CSR_MISA:                    read_data = MISA_VALUE;
            CSR_MIE:                     read_data = mie_reg_q;
            CSR_MTVEC:                   read_data = mtvec_q;
            CSR_MSCRATCH:                read_data = mscratch_q;
            CSR_MEPC:                    read_data = mepc_q;
            CSR_MCAUSE:                  read_data = mcause_q;
            CSR_MTVAL:                   read_data = mtval_q;
            CSR_MCYCLE,   CSR_CYCLE:     read_data = cycle_q[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:    read_data = cycle_q[63:32];
            CSR_MINSTRET, CSR_INSTRET:   read_data = instret_q[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: read_data = instret_q[63:32];
            CSR_MHARTID:                 read_data = HART_ID;
            default: begin
                read_data    = 32'h0000_0000;
                read_illegal = 1'b1;
            end
        endcase
    end

    // Write legality; misa writes are silently ignored rather than flagged.
    always_comb begin
        if (write_enable && (write_index != CSR_MISA)) begin
            write_illegal = !csr_implemented(write_index) || (write_index[11:10] == 2'b11);
        end else begin
            write_illegal = 1'b0;
        end
    end

    assign sw_write_s    = write_enable && !write_illegal;
    // Trap and mret own mstatus; trap also owns mepc/mcause/mtval.
    assign wr_mstatus_s  = sw_write_s && !trap_valid && !mret_valid && (write_index == CSR_MSTATUS);
    assign wr_trap_csr_s = sw_write_s && !trap_valid;

    // Next-state for all architectural registers and counters.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mie_reg_d  = mie_reg_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        cycle_d    = cycle_q + 64'd1;
        instret_d  = instret_q + {63'd0, instret_increment};

        if (trap_valid) begin
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            mepc_d   = {trap_pc[31:2], 2'b00};
            mcause_d = trap_cause;
            mtval_d  = trap_value;
        end else if (mret_valid) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_mstatus_s) begin
            mie_d  = write_data[3];
            mpie_d = write_data[7];
        end else begin
            mie_d  = mie_q;
            mpie_d = mpie_q;
        end

        if (wr_trap_csr_s && (write_index == CSR_MEPC)) begin
            mepc_d = {write_data[31:2], 2'b00};
        end else if (wr_trap_csr_s && (write_index == CSR_MCAUSE)) begin
            mcause_d = write_data;
        end else if (wr_trap_csr_s && (write_index == CSR_MTVAL)) begin
            mtval_d = write_data;
        end else begin
            mtval_d = mtval_d;
        end

        if (sw_write_s) begin
            case (write_index)
                CSR_MIE:       mie_reg_d  = write_data;
                CSR_MTVEC:     mtvec_d    = mtvec_legalize(write_data);
                CSR_MSCRATCH:  mscratch_d = write_data;
                CSR_MCYCLE:    cycle_d    = {cycle_q[63:32], write_data};
                CSR_MCYCLEH:   cycle_d    = {write_data, cycle_q[31:0]};
                CSR_MINSTRET:  instret_d  = {instret_q[63:32], write_data};
                CSR_MINSTRETH: instret_d  = {write_data, instret_q[31:0]};
                default:       mie_reg_d  = mie_reg_q;
            endcase
        end else begin
            mie_reg_d = mie_reg_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mie_reg_q  <= 32'h0000_0000;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= 32'h0000_0000;
            mepc_q     <= 32'h0000_0000;
            mcause_q   <= 32'h0000_0000;
            mtval_q    <= 32'h0000_0000;
            cycle_q    <= 64'd0;
            instret_q  <= 64'd0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mie_reg_q  <= mie_reg_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            cycle_q    <= cycle_d;
            instret_q  <= instret_d;
        end
    end

    assign tvec_base_s = {mtvec_q[31:2], 2'b00};

    // Vectored mode offsets interrupts by 4 x cause, wrapping at 32 bits.
    always_comb begin
        if ((mtvec_q[1:0] == 2'b01) && trap_cause[31]) begin
            trap_vector = tvec_base_s + {trap_cause[29:0], 2'b00};
        end else begin
            trap_vector = tvec_base_s;
        end
    end

    assign mret_target             = mepc_q;
    assign global_interrupt_enable = mie_q;

endmodule

// File: tb/tb_control_status_register_file.sv
// Directed, table-driven bench for control_status_register_file with hand-computed
// expectations, plus short sequences for traps, mret, counter wrap and async reset.
module tb_control_status_register_file;

    logic        clk;
    logic        reset;
    logic [11:0] read_index;
    logic [31:0] read_data;
    logic        read_illegal;
    logic        write_enable;
    logic [11:0] write_index;
    logic [31:0] write_data;
    logic        write_illegal;
    logic        instret_increment;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_value;
    logic        mret_valid;
    logic [31:0] trap_vector;
    logic [31:0] mret_target;
    logic        global_interrupt_enable;

    int checks   = 0;
    int failures = 0;

    control_status_register_file dut (
        .clk                     (clk),
        .reset                   (reset),
        .read_index              (read_index),
        .read_data               (read_data),
        .read_illegal            (read_illegal),
        .write_enable            (write_enable),
        .write_index             (write_index),
        .write_data              (write_data),
        .write_illegal           (write_illegal),
        .instret_increment       (instret_increment),
        .trap_valid              (trap_valid),
        .trap_cause              (trap_cause),
        .trap_pc                 (trap_pc),
        .trap_value              (trap_value),
        .mret_valid              (mret_valid),
        .trap_vector             (trap_vector),
        .mret_target             (mret_target),
        .global_interrupt_enable (global_interrupt_enable)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [11:0] idx;
        logic [31:0] exp;
        logic        ill;
    } rd_vec_t;

    typedef struct {
        logic [11:0] idx;
        logic [31:0] data;
        logic [31:0] exp;
        logic        ill;
    } wr_vec_t;

    rd_vec_t rd_tab[13];
    wr_vec_t wr_tab[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [11:0] idx, input logic [31:0] exp);
        read_index = idx;
        #1;
        chk(name, read_data, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rd_tab[0]  = '{12'h300, 32'h0000_1800, 1'b0};
        rd_tab[1]  = '{12'h301, 32'h4000_1104, 1'b0};
        rd_tab[2]  = '{12'h304, 32'h0000_0000, 1'b0};
        rd_tab[3]  = '{12'h305, 32'h0000_0000, 1'b0};
        rd_tab[4]  = '{12'h340, 32'h0000_0000, 1'b0};
        rd_tab[5]  = '{12'h341, 32'h0000_0000, 1'b0};
        rd_tab[6]  = '{12'h342, 32'h0000_0000, 1'b0};
        rd_tab[7]  = '{12'h343, 32'h0000_0000, 1'b0};
        rd_tab[8]  = '{12'hF14, 32'h0000_0000, 1'b0};
        rd_tab[9]  = '{12'h7C0, 32'h0000_0000, 1'b1};
        rd_tab[10] = '{12'h000, 32'h0000_0000, 1'b1};
        rd_tab[11] = '{12'hC01, 32'h0000_0000, 1'b1};
        rd_tab[12] = '{12'h3FF, 32'h0000_0000, 1'b1};

        wr_tab[0]  = '{12'h304, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        wr_tab[1]  = '{12'h340, 32'h1234_5678, 32'h1234_5678, 1'b0};
        wr_tab[2]  = '{12'h341, 32'hAAAA_AAAB, 32'hAAAA_AAA8, 1'b0};
        wr_tab[3]  = '{12'h342, 32'h8000_0003, 32'h8000_0003, 1'b0};
        wr_tab[4]  = '{12'h343, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        wr_tab[5]  = '{12'h305, 32'h8000_0102, 32'h8000_0100, 1'b0};
        wr_tab[6]  = '{12'h305, 32'h8000_0101, 32'h8000_0101, 1'b0};
        wr_tab[7]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888, 1'b0};
        wr_tab[8]  = '{12'h300, 32'h0000_0008, 32'h0000_1808, 1'b0};
        wr_tab[9]  = '{12'h301, 32'h0000_0000, 32'h4000_1104, 1'b0};
        wr_tab[10] = '{12'hF14, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        wr_tab[11] = '{12'h7C0, 32'h0000_0001, 32'h0000_0000, 1'b1};

        reset = 1'b0;
        read_index = 12'h000;
        write_enable = 1'b0;
        write_index = 12'h000;
        write_data = 32'h0;
        instret_increment = 1'b0;
        trap_valid = 1'b0;
        trap_cause = 32'h0;
        trap_pc = 32'h0;
        trap_value = 32'h0;
        mret_valid = 1'b0;

        #3;
        rd_chk("in_reset_mstatus", 12'h300, 32'h0000_1800);
        chk("in_reset_gie", {31'd0, global_interrupt_enable}, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rd_chk("mcycle_after_5", 12'hB00, 32'd5);

        for (int i = 0; i < 13; i++) begin
            tick();
            rd_chk($sformatf("reset_read_%h", rd_tab[i].idx), rd_tab[i].idx, rd_tab[i].exp);
            chk($sformatf("reset_read_ill_%h", rd_tab[i].idx), {31'd0, read_illegal}, {31'd0, rd_tab[i].ill});
        end

        for (int i = 0; i < 12; i++) begin
            tick();
            write_enable = 1'b1;
            write_index  = wr_tab[i].idx;
            write_data   = wr_tab[i].data;
            #1;
            chk($sformatf("wr_ill_%0d", i), {31'd0, write_illegal}, {31'd0, wr_tab[i].ill});
            tick();
            write_enable = 1'b0;
            rd_chk($sformatf("wr_readback_%0d", i), wr_tab[i].idx, wr_tab[i].exp);
        end

        // mtvec = 0x8000_0101 (vectored) from the write table
        trap_cause = 32'h8000_0007;
        #1;
        chk("tvec_vectored_irq", trap_vector, 32'h8000_011C);
        trap_cause = 32'h0000_0002;
        #1;
        chk("tvec_exception", trap_vector, 32'h8000_0100);
        trap_cause = 32'hFFFF_FFFF;
        #1;
        chk("tvec_wrap", trap_vector, 32'h8000_00FC);

        tick();
        trap_valid = 1'b1;
        trap_pc    = 32'h0000_1236;
        trap_cause = 32'h0000_0002;
        trap_value = 32'hBAD0_0001;
        tick();
        trap_valid = 1'b0;
        rd_chk("trap_mepc", 12'h341, 32'h0000_1234);
        rd_chk("trap_mstatus", 12'h300, 32'h0000_1880);
        rd_chk("trap_mcause", 12'h342, 32'h0000_0002);
        rd_chk("trap_mtval", 12'h343, 32'hBAD0_0001);
        chk("trap_gie", {31'd0, global_interrupt_enable}, 32'd0);
        mret_valid = 1'b1;
        tick();
        mret_valid = 1'b0;
        rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);
        chk("mret_gie", {31'd0, global_interrupt_enable}, 32'd1);
        chk("mret_target", mret_target, 32'h0000_1234);

        trap_valid   = 1'b1;
        trap_pc      = 32'h2000_0003;
        trap_cause   = 32'h0000_000B;
        write_enable = 1'b1;
        write_index  = 12'h341;
        write_data   = 32'hAAAA_AAA8;
        tick();
        rd_chk("trap_beats_mepc_write", 12'h341, 32'h2000_0000);
        rd_chk("trap_beats_write_status", 12'h300, 32'h0000_1880);
        trap_pc     = 32'h3000_0000;
        write_index = 12'h340;
        write_data  = 32'h0000_0055;
        tick();
        trap_valid   = 1'b0;
        write_enable = 1'b0;
        rd_chk("trap_with_mscratch_write", 12'h340, 32'h0000_0055);
        rd_chk("trap_with_mscratch_mepc", 12'h341, 32'h3000_0000);
        rd_chk("trap2_mstatus", 12'h300, 32'h0000_1800);

        mret_valid   = 1'b1;
        write_enable = 1'b1;
        write_index  = 12'h300;
        write_data   = 32'h0000_0088;
        tick();
        write_enable = 1'b0;
        rd_chk("mret_beats_mstatus_write", 12'h300, 32'h0000_1880);
        tick();
        mret_valid = 1'b0;
        rd_chk("mret_again", 12'h300, 32'h0000_1888);

        trap_valid = 1'b1;
        mret_valid = 1'b1;
        trap_pc    = 32'h4000_0004;
        tick();
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        rd_chk("trap_and_mret_status", 12'h300, 32'h0000_1880);
        rd_chk("trap_and_mret_mepc", 12'h341, 32'h4000_0004);

        write_enable      = 1'b1;
        write_index       = 12'hB82;
        write_data        = 32'h0000_0010;
        instret_increment = 1'b1;
        tick();
        rd_chk("instreth_write", 12'hB82, 32'h0000_0010);
        rd_chk("instret_no_inc_on_write", 12'hB02, 32'h0000_0000);
        write_index = 12'hB02;
        write_data  = 32'hFFFF_FFFE;
        tick();
        write_enable = 1'b0;
        rd_chk("instret_write", 12'hB02, 32'hFFFF_FFFE);
        tick();
        rd_chk("instret_alias", 12'hC02, 32'hFFFF_FFFF);
        tick();
        instret_increment = 1'b0;
        rd_chk("instret_wrap_lo", 12'hB02, 32'h0000_0000);
        rd_chk("instret_wrap_hi", 12'hB82, 32'h0000_0011);
        rd_chk("instreth_alias", 12'hC82, 32'h0000_0011);
        tick();
        rd_chk("instret_hold", 12'hB02, 32'h0000_0000);

        write_enable = 1'b1;
        write_index  = 12'hB00;
        write_data   = 32'hFFFF_FFFF;
        tick();
        write_enable = 1'b0;
        rd_chk("mcycle_write", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("mcycleh_on_write_edge", 12'hB80, 32'h0000_0000);
        tick();
        rd_chk("mcycle_wrap_lo", 12'hB00, 32'h0000_0000);
        rd_chk("mcycle_wrap_hi", 12'hB80, 32'h0000_0001);
        rd_chk("cycle_alias", 12'hC00, 32'h0000_0000);
        rd_chk("cycleh_alias", 12'hC80, 32'h0000_0001);
        write_enable = 1'b1;
        write_index  = 12'hC00;
        write_data   = 32'h0001_2345;
        #1;
        chk("cycle_write_illegal", {31'd0, write_illegal}, 32'd1);
        tick();
        write_enable = 1'b0;
        rd_chk("cycle_write_ignored", 12'hB00, 32'h0000_0001);

        tick();
        trap_valid   = 1'b1;
        trap_pc      = 32'h5000_0000;
        write_enable = 1'b1;
        write_index  = 12'h340;
        write_data   = 32'h0000_0077;
        #2;
        reset = 1'b0;
        rd_chk("async_reset_mstatus", 12'h300, 32'h0000_1800);
        rd_chk("async_reset_mepc", 12'h341, 32'h0000_0000);
        rd_chk("async_reset_mscratch", 12'h340, 32'h0000_0000);
        rd_chk("async_reset_mtvec", 12'h305, 32'h0000_0000);
        rd_chk("async_reset_mcycle", 12'hB00, 32'h0000_0000);
        rd_chk("async_reset_minstreth", 12'hB82, 32'h0000_0000);
        chk("async_reset_gie", {31'd0, global_interrupt_enable}, 32'd0);
        trap_valid   = 1'b0;
        write_enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rd_chk("mcycle_after_rereset", 12'hB00, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
